// File: rtl/hilo_unit_if.sv
// Issue/readback bundle between the datapath and the HI/LO multiply/divide unit.
// The datapath is the master: it issues operations and selects which half to read.
interface hilo_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rd_sel;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b, rd_sel,
        input  rdata, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b, rd_sel,
        output rdata, busy, done, div_zero
    );
endinterface

// File: rtl/hilo_unit.sv
// Iterative unsigned multiply/divide engine that owns the HI/LO register pair.
// One operation takes WIDTH iterations; results commit to HI/LO on the last one.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    hilo_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;      // P for multiply, R for divide (R < b always fits)
    logic [WIDTH-1:0] q;        // low half of the product / quotient
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    cnt;
    logic             dz;       // divide by zero seen at accept; iterations skipped
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_p;
    logic [WIDTH-1:0] mul_q;
    logic [WIDTH:0]   div_rs;
    logic [WIDTH:0]   div_t;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] div_q;

    // One iteration of shift-add multiply and restoring divide from the current state.
    always_comb begin
        mul_sum = {1'b0, acc} + (q[0] ? {1'b0, b_r} : '0);
        mul_p   = mul_sum[WIDTH:1];
        mul_q   = {mul_sum[0], q[WIDTH-1:1]};

        // Shifted remainder stays below 2*b, so the trial sign bit is exact.
        div_rs  = {acc, q[WIDTH-1]};
        div_t   = div_rs - {1'b0, b_r};
        div_r   = div_rs[WIDTH-1:0];
        div_q   = {q[WIDTH-2:0], 1'b0};
        if (!div_t[WIDTH]) begin
            div_r = div_t[WIDTH-1:0];
            div_q = {q[WIDTH-2:0], 1'b1};
        end
    end

    // Control FSM, iteration datapath and HI/LO commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            q      <= '0;
            b_r    <= '0;
            cnt    <= '0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        q      <= bus.a;
                        b_r    <= bus.b;
                        cnt    <= '0;
                        dz     <= bus.op && (bus.b == '0);
                        dz_r   <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= bus.op ? DIV : MUL;
                    end
                end
                MUL: begin
                    acc <= mul_p;
                    q   <= mul_q;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        hi     <= mul_p;
                        lo     <= mul_q;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
                DIV: begin
                    // Divide by zero idles through the same cycle count; q still holds a.
                    if (!dz) begin
                        acc <= div_r;
                        q   <= div_q;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        if (dz) begin
                            hi   <= q;
                            lo   <= '1;
                            dz_r <= 1'b1;
                        end else begin
                            hi <= div_r;
                            lo <= div_q;
                        end
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata    = bus.rd_sel ? hi : lo;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: products, quotients, divide by zero,
// busy-time start rejection, back-to-back issue and mid-operation reset.
module tb_hilo_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat;
    logic [31:0] v;

    hilo_unit_if #(.WIDTH(32)) bus ();

    hilo_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic sel, output logic [31:0] val);
        bus.rd_sel = sel;
        #1;
        val = bus.rdata;
    endtask

    // Accept an operation at the next edge, then scramble the operand pins.
    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        step();
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h1234_5678;
    endtask

    // Step until done; lat = edges after the accept edge. busy must stay high until then.
    task automatic wait_done(input int from, output int l);
        logic bad;
        bad = 1'b0;
        l   = -1;
        for (int i = from + 1; i <= 60; i++) begin
            step();
            if (bus.busy && bus.done) bad = 1'b1;
            if (bus.done) begin
                l = i;
                break;
            end
            if (!bus.busy) bad = 1'b1;
        end
        chk("busy_profile", {63'd0, bad}, 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.rd_sel = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // reset state
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_dz", {63'd0, bus.div_zero}, 64'd0);
        rd(1'b0, v); chk("rst_lo", {32'd0, v}, 64'd0);
        rd(1'b1, v); chk("rst_hi", {32'd0, v}, 64'd0);

        // 7 x 6
        issue(1'b0, 32'd7, 32'd6);
        chk("mul1_busy", {63'd0, bus.busy}, 64'd1);
        wait_done(0, lat);
        chk("mul1_lat", 64'(lat), 64'd32);
        rd(1'b0, v); chk("mul1_lo", {32'd0, v}, 64'h2A);
        rd(1'b1, v); chk("mul1_hi", {32'd0, v}, 64'h0);
        step();
        chk("mul1_done_low", {63'd0, bus.done}, 64'd0);

        // carry-out path
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, lat);
        chk("mul2_lat", 64'(lat), 64'd32);
        rd(1'b0, v); chk("mul2_lo", {32'd0, v}, 64'h0000_0001);
        rd(1'b1, v); chk("mul2_hi", {32'd0, v}, 64'hFFFF_FFFE);

        // 100 / 7
        issue(1'b1, 32'd100, 32'd7);
        wait_done(0, lat);
        chk("div1_lat", 64'(lat), 64'd32);
        rd(1'b0, v); chk("div1_q", {32'd0, v}, 64'd14);
        rd(1'b1, v); chk("div1_r", {32'd0, v}, 64'd2);
        chk("div1_dz", {63'd0, bus.div_zero}, 64'd0);

        // 5 / 0, then 9 / 3 clears the flag at accept
        issue(1'b1, 32'd5, 32'd0);
        chk("dz_flag_early", {63'd0, bus.div_zero}, 64'd0);
        wait_done(0, lat);
        chk("dz_lat", 64'(lat), 64'd32);
        chk("dz_flag", {63'd0, bus.div_zero}, 64'd1);
        rd(1'b0, v); chk("dz_lo", {32'd0, v}, 64'hFFFF_FFFF);
        rd(1'b1, v); chk("dz_hi", {32'd0, v}, 64'd5);
        step();
        chk("dz_flag_hold", {63'd0, bus.div_zero}, 64'd1);
        issue(1'b1, 32'd9, 32'd3);
        chk("dz_flag_clr", {63'd0, bus.div_zero}, 64'd0);
        wait_done(0, lat);
        rd(1'b0, v); chk("div2_q", {32'd0, v}, 64'd3);
        rd(1'b1, v); chk("div2_r", {32'd0, v}, 64'd0);

        // 3 x 4 with an ignored start mid-flight, then back-to-back 2 / 1
        issue(1'b0, 32'd3, 32'd4);
        repeat (9) step();
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 32'd2;
        bus.b     = 32'd1;
        step();
        bus.start = 1'b0;
        rd(1'b0, v); chk("busy_read_old", {32'd0, v}, 64'd3);
        wait_done(10, lat);
        chk("mul3_lat", 64'(lat), 64'd32);
        rd(1'b0, v); chk("mul3_lo", {32'd0, v}, 64'd12);
        rd(1'b1, v); chk("mul3_hi", {32'd0, v}, 64'd0);
        issue(1'b1, 32'd2, 32'd1);
        chk("b2b_busy", {63'd0, bus.busy}, 64'd1);
        chk("b2b_done_low", {63'd0, bus.done}, 64'd0);
        wait_done(0, lat);
        chk("b2b_lat", 64'(lat), 64'd32);
        rd(1'b0, v); chk("b2b_q", {32'd0, v}, 64'd2);
        rd(1'b1, v); chk("b2b_r", {32'd0, v}, 64'd0);

        // reset mid-operation: no commit, HI/LO cleared, no done
        issue(1'b0, 32'h0001_0000, 32'h0001_0000);
        repeat (14) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        rd(1'b0, v); chk("abort_lo", {32'd0, v}, 64'd0);
        rd(1'b1, v); chk("abort_hi", {32'd0, v}, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (bus.done || bus.busy) seen = 1'b1;
            end
            chk("abort_quiet", {63'd0, seen}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
